// File: rtl/mp_serdes_pkg.sv
// Shared types and constants for the mp serializer/deserializer path.
package mp_serdes_pkg;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam int ELS_DEFAULT = 256;
   localparam bit LSB_FIRST   = 1'b1;
   localparam bit MSB_FIRST   = 1'b0;
endpackage

// File: rtl/mp_deser_frame_ctr.sv
// Bit-index counter for the deserializer: wraps per word, holds on slip,
// restarts at 1 on align (the align cycle's bit is bit 0).
module mp_deser_frame_ctr
   import mp_serdes_pkg::*;
#(
   parameter int els_p = ELS_DEFAULT,
   localparam int idx_w = $clog2(els_p)
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             run,
   input  logic             start,
   input  logic             slip,
   output logic [idx_w-1:0] idx,
   output logic             wrap,
   output logic             half
);
   localparam logic [idx_w-1:0] LAST = idx_w'(els_p - 1);
   localparam logic [idx_w-1:0] HALF = idx_w'(els_p / 2);

   logic [idx_w-1:0] idx_next;

   always_comb begin
      idx_next = idx;
      wrap     = 1'b0;
      if (start) begin
         idx_next = idx_w'(1);
      end else if (run && !slip) begin
         if (idx == LAST) begin
            idx_next = '0;
            wrap     = 1'b1;
         end else begin
            idx_next = idx + idx_w'(1);
         end
      end
   end

   // Word clock is high for the first half of the word, judged on the updated index
   assign half = (idx_next < HALF);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) idx <= '0;
      else           idx <= idx_next;
   end
endmodule

// File: rtl/mp_deserializer_top.sv
// Serial-to-parallel receiver: reassembles els_p-bit words from a 1-bit
// stream with align-based framing, bit slip and a regenerated word clock.
module mp_deserializer_top
   import mp_serdes_pkg::*;
#(
   parameter int els_p       = ELS_DEFAULT,
   parameter bit lsb_first_p = LSB_FIRST
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             data_i,
   input  logic             align_i,
   input  logic             slip_i,
   output logic [els_p-1:0] data_o,
   output logic             v_o,
   output logic             word_clk_o,
   output logic             locked_o,
   output logic             align_err_o
);
   localparam int idx_w = $clog2(els_p);
   localparam logic [idx_w-1:0] LAST = idx_w'(els_p - 1);

   state_t           state_q, state_d;
   logic             run, store, wrap, half;
   logic [idx_w-1:0] idx, wr_idx, wr_pos;
   logic [els_p-1:0] sreg, word_next;

   mp_deser_frame_ctr #(.els_p(els_p)) u_ctr (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .run      (run),
      .start    (align_i),
      .slip     (slip_i),
      .idx      (idx),
      .wrap     (wrap),
      .half     (half)
   );

   always_comb begin
      state_d = state_q;
      run     = 1'b0;
      case (state_q)
         IDLE:    if (align_i) state_d = RUN;
         RUN:     run = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   // Align always writes bit 0, whatever the current index
   assign store  = align_i || (run && !slip_i);
   assign wr_idx = align_i ? '0 : idx;
   assign wr_pos = lsb_first_p ? wr_idx : (LAST - wr_idx);

   always_comb begin
      word_next         = sreg;
      word_next[wr_pos] = data_i;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         sreg        <= '0;
         data_o      <= '0;
         v_o         <= 1'b0;
         word_clk_o  <= 1'b0;
         align_err_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         v_o         <= wrap;
         align_err_o <= run && align_i && (idx != '0);
         if (store)           sreg       <= word_next;
         if (wrap)            data_o     <= word_next;
         if (run || align_i)  word_clk_o <= half;
      end
   end

   assign locked_o = (state_q == RUN);
endmodule

// File: tb/tb_mp_deserializer_top.sv
// Bench for mp_deserializer_top: directed framing scenarios plus a random
// stream, checked against a queue-based model of the received bits.
module tb_mp_deserializer_top;
   logic         clk, rst_n;
   logic         d8, a8, s8;
   logic [7:0]   data8;
   logic         v8, wclk8, lock8, err8;
   logic         d256, a256, s256;
   logic [255:0] data256;
   logic         v256, wclk256, lock256, err256;

   int checks   = 0;
   int failures = 0;

   // Model state: bits received so far in the current word
   bit         m_locked;
   bit         mq[$];
   logic [7:0] m_data;
   bit         m_v, m_wclk, m_err;

   logic [7:0] wpat, vpat, epat;

   mp_deserializer_top #(.els_p(8), .lsb_first_p(1'b1)) dut8 (
      .clk_i(clk), .reset_ni(rst_n), .data_i(d8), .align_i(a8), .slip_i(s8),
      .data_o(data8), .v_o(v8), .word_clk_o(wclk8), .locked_o(lock8),
      .align_err_o(err8)
   );

   mp_deserializer_top #(.els_p(256), .lsb_first_p(1'b0)) dut256 (
      .clk_i(clk), .reset_ni(rst_n), .data_i(d256), .align_i(a256), .slip_i(s256),
      .data_o(data256), .v_o(v256), .word_clk_o(wclk256), .locked_o(lock256),
      .align_err_o(err256)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; mq.delete(); m_data = '0; m_v = 0; m_wclk = 0; m_err = 0;
   endtask

   task automatic model_step(input bit d, input bit a, input bit s);
      m_v = 0; m_err = 0;
      if (a) begin
         m_err = m_locked && (mq.size() != 0);
         mq.delete();
         mq.push_back(d);
         m_locked = 1;
      end else if (m_locked && !s) begin
         mq.push_back(d);
         if (mq.size() == 8) begin
            for (int k = 0; k < 8; k++) m_data[k] = mq[k];
            m_v = 1;
            mq.delete();
         end
      end
      if (m_locked) m_wclk = (mq.size() < 4);
   endtask

   task automatic check8(input string tag);
      chk({tag, "_data"}, data8, m_data);
      chk({tag, "_v"},    v8,    m_v);
      chk({tag, "_wclk"}, wclk8, m_wclk);
      chk({tag, "_lock"}, lock8, m_locked);
      chk({tag, "_err"},  err8,  m_err);
   endtask

   // One serial cycle on the 8-bit instance: drive at negedge, sample at next negedge
   task automatic cyc8(input string tag, input bit d, input bit a, input bit s);
      d8 = d; a8 = a; s8 = s;
      @(posedge clk);
      model_step(d, a, s);
      @(negedge clk);
      check8(tag);
   endtask

   task automatic send_word(input string tag, input logic [7:0] w, input bit align_first);
      for (int k = 0; k < 8; k++) begin
         cyc8(tag, w[k], align_first && (k == 0), 1'b0);
         wpat[k] = wclk8; vpat[k] = v8; epat[k] = err8;
      end
   endtask

   initial begin
      logic [7:0]   w;
      logic [255:0] exp256;
      bit           vseen;
      clk = 0; rst_n = 0;
      d8 = 0; a8 = 0; s8 = 0; d256 = 0; a256 = 0; s256 = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check8("reset");
      chk("reset_data256", data256, '0);
      chk("reset_lock256", lock256, 1'b0);
      rst_n = 1;

      cyc8("idle", 1'b1, 1'b0, 1'b1);

      send_word("t1", 8'h4D, 1'b1);
      chk("t1_data_const", data8, 8'h4D);
      chk("t1_v_const", v8, 1'b1);
      chk("t1_lock_const", lock8, 1'b1);

      send_word("t2a", 8'hA5, 1'b1);
      chk("t2a_data_const", data8, 8'hA5);
      chk("t2a_realign_noerr", epat, 8'h00);
      send_word("t2b", 8'h3C, 1'b0);
      chk("t2b_data_const", data8, 8'h3C);
      send_word("t2c", 8'hFF, 1'b0);
      chk("t2c_data_const", data8, 8'hFF);
      chk("t2c_wclk_pattern", wpat, 8'h87);
      chk("t2c_v_pattern", vpat, 8'h80);

      w = 8'hA5;
      cyc8("t3", w[0], 1'b1, 1'b0);
      cyc8("t3", 1'($urandom), 1'b0, 1'b1);
      for (int k = 1; k < 8; k++) cyc8("t3", w[k], 1'b0, 1'b0);
      chk("t3_slip_data", data8, 8'hA5);
      chk("t3_slip_v", v8, 1'b1);

      cyc8("t4", 1'($urandom), 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cyc8("t4", 1'($urandom), 1'b0, 1'b0);
      send_word("t4a", 8'h3C, 1'b1);
      chk("t4_err_pattern", epat, 8'h01);
      chk("t4_data_const", data8, 8'h3C);
      send_word("t4b", 8'hC3, 1'b0);
      chk("t4b_data_const", data8, 8'hC3);

      send_word("t5a", 8'h5A, 1'b1);
      for (int k = 0; k < 3; k++) cyc8("t5", 1'($urandom), 1'b0, 1'b0);
      rst_n = 0;
      #1;
      model_reset();
      check8("t5_async_reset");
      @(negedge clk);
      rst_n = 1;
      vseen = 0;
      for (int i = 0; i < 20; i++) begin
         cyc8("t5_norelock", 1'($urandom), 1'b0, 1'($urandom_range(0, 3) == 0));
         vseen |= v8;
      end
      chk("t5_no_v", vseen, 1'b0);

      for (int i = 0; i < 400; i++)
         cyc8("rand", 1'($urandom), 1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 7) == 0));

      a8 = 0; s8 = 0;
      d256 = 1; a256 = 1;
      @(negedge clk);
      d256 = 0; a256 = 0;
      repeat (254) @(negedge clk);
      chk("t7_v_before", v256, 1'b0);
      @(negedge clk);
      exp256 = '0;
      exp256[255] = 1'b1;
      chk("t7_v", v256, 1'b1);
      chk("t7_data", data256, exp256);
      chk("t7_lock", lock256, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mp_deserializer_top.md
Name: mp_deserializer_top

Overview:
Receive-side counterpart of the 256:1 serializer path. Samples a 1-bit serial stream on the fast serial clock and reassembles it into els_p-bit parallel words. Emits a one-cycle valid strobe per word and a regenerated divided word clock for the slow parallel domain. Frame alignment comes from an align pulse, with bit-slip available for link training.

Parameters:
els_p, 256, bits per word; legal range 4..1024, even; counter width is $clog2(els_p)
lsb_first_p, 1, 1: first received bit lands in data_o[0]; 0: first bit lands in data_o[els_p-1]

Ports:
clk_i  in  1  serial bit clock; all logic on posedge
reset_ni  in  1  asynchronous active-low reset
data_i  in  1  serial data bit, sampled every posedge
align_i  in  1  marks that this cycle's data_i is bit 0 of a word
slip_i  in  1  discard this cycle's bit; shifts frame boundary one bit later
data_o  out  els_p  last fully received word, registered
v_o  out  1  one-cycle pulse when data_o updates
word_clk_o  out  1  regenerated slow clock: high for bit indices 0..els_p/2-1, low otherwise; registered, glitch-free
locked_o  out  1  state == RUN
align_err_o  out  1  one-cycle pulse: align_i seen in RUN while bit index != 0

Behaviour:
- Reset (reset_ni=0, async assert, sync release): state=IDLE, bit index=0, shift reg=0, data_o=0, v_o=0, word_clk_o=0, locked_o=0, align_err_o=0.
- FSM states IDLE and RUN.
  - IDLE: data_i, slip_i ignored; outputs hold. align_i=1 -> RUN; the current data_i is stored as bit 0; index becomes 1.
  - RUN: each cycle, store data_i at the current index, then index++.
- Word completion:
  - When the bit at index els_p-1 is stored, index wraps to 0 and the full word (including that bit) loads into data_o.
  - v_o=1 on the following cycle only. Latency is 1 clk from sampling the last bit to data_o/v_o.
  - Consecutive words: v_o pulses every els_p cycles, with no gap.
- slip_i=1 in RUN (align_i=0): bit discarded; index and shift reg unchanged for that cycle. Repeated slips each delay the frame by one bit. A slip on the wrap cycle delays the wrap; the word is not emitted.
- align_i=1 in RUN:
  - Partial word is discarded, current bit is stored as bit 0, index=1.
  - If the prior index != 0, align_err_o pulses the next cycle.
  - If the prior index == 0, this is a consistent realign: no error, and no word is lost because the previous word was already emitted.
- align_i and slip_i together: align wins, slip ignored.
- word_clk_o: registered from the index value after update; toggles exactly twice per word. Its rising edge is coincident with v_o.
- Bit order:
  - lsb_first_p=1: bit k goes to data_o[k].
  - lsb_first_p=0: bit k goes to data_o[els_p-1-k].
- Reset mid-word: partial word lost, returns to IDLE; relock requires align_i.
- No internal FIFO or backpressure; the consumer must take data_o within els_p cycles.

Decomposition:
- Shared package mp_serdes_pkg: state enum (IDLE, RUN), default word width constant 256, bit-order constant names.
- One sub-module mp_deser_frame_ctr: index counter with wrap, slip hold and align restart. It outputs index, wrap pulse and half-word flag.
- The top holds the FSM, shift/capture register and output registers.

Test Plan:
- els_p=8, lsb_first_p=1: align_i with bits 1,0,1,1,0,0,1,0 -> data_o=8'h4D and v_o high 1 cycle after the 8th bit; locked_o=1.
- Continuous stream: 3 back-to-back words 8'hA5, 8'h3C, 8'hFF after one align -> v_o pulses 8 cycles apart with the matching data_o; word_clk_o period is 8 clk, high 4.
- Slip: stream 8'hA5 sent one bit late, with slip_i asserted on the first bit after align -> data_o=8'hA5 after 9 cycles total.
- align_i asserted at index 5 -> align_err_o pulses once, partial discarded; the next full word is correct. align_i at index 0 -> no error.
- Reset asserted at index 3 of the 2nd word -> all outputs 0 immediately; after release, no v_o until a new align_i.
- els_p=256, lsb_first_p=0: send word with data_o[255]=1, rest 0 (single 1 as the first bit) -> data_o=256'h8000...0.
